// File: rtl/trdb_pkg.sv
// Shared trace types plus the header/field layout used by the receive-side packet decoder.
package trdb_pkg;

  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'd0,
    F_DIFF_DELTA = 2'd1,
    F_ADDR_ONLY  = 2'd2,
    F_SYNC       = 2'd3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'd0,
    SF_TRAP    = 2'd1,
    SF_CONTEXT = 2'd2,
    SF_SUPPORT = 2'd3
  } trdb_f_sync_subformat_e;

  typedef enum logic {
    SF_PBC = 1'b0,
    SF_JTC = 1'b1
  } trdb_f_opt_ext_subformat_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    OUT     = 2'd2,
    DROP    = 2'd3
  } trdb_dec_state_e;

  localparam int unsigned HDR_LEN_W     = 5;
  localparam int unsigned HDR_FLOW_LSB  = 5;
  localparam int unsigned HDR_RSVD_BIT  = 7;
  localparam int unsigned FORMAT_LSB    = 0;
  localparam int unsigned SUBFORMAT_LSB = 2;

endpackage

// File: rtl/trdb_packet_decoder.sv
// Reassembles length-prefixed trace packets from a byte stream and presents one decoded
// packet per valid/ready handshake; malformed or oversized packets are skipped and counted.
//
// state   | meaning
// IDLE    | waiting for a header byte (L=0 headers are filler)
// PAYLOAD | collecting L payload bytes into the payload register
// OUT     | holding a decoded packet until the consumer takes it
// DROP    | discarding the payload of a rejected packet
module trdb_packet_decoder
  import trdb_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD_BYTES = 16,
  parameter int unsigned CNT_W             = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  input  logic [7:0]                     in_data_i,
  output logic                           in_ready_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output trdb_format_e                   out_format_o,
  output trdb_f_sync_subformat_e         out_sync_subformat_o,
  output trdb_f_opt_ext_subformat_e      out_opt_ext_subformat_o,
  output logic [1:0]                     out_flow_o,
  output logic [4:0]                     out_len_o,
  output logic [8*MAX_PAYLOAD_BYTES-1:0] out_payload_o,
  output logic                           err_o,
  output logic [CNT_W-1:0]               dropped_cnt_o
);

  localparam logic [HDR_LEN_W-1:0] MAX_LEN = HDR_LEN_W'(MAX_PAYLOAD_BYTES);

  trdb_dec_state_e state_q, state_d;

  logic [8*MAX_PAYLOAD_BYTES-1:0] payload_q;
  logic [HDR_LEN_W-1:0]           len_q, idx_q, remain_q;
  logic [1:0]                     flow_q;
  logic                           err_q;
  logic [CNT_W-1:0]               cnt_q;

  logic [HDR_LEN_W-1:0] hdr_len;
  logic [1:0]           hdr_flow;
  logic                 hdr_rsvd;
  logic                 byte_fire;
  logic                 start_pkt, start_drop, store_byte, drop_done;

  assign hdr_len   = in_data_i[HDR_LEN_W-1:0];
  assign hdr_flow  = in_data_i[HDR_FLOW_LSB +: 2];
  assign hdr_rsvd  = in_data_i[HDR_RSVD_BIT];
  assign byte_fire = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b1;
    out_valid_o = 1'b0;
    start_pkt   = 1'b0;
    start_drop  = 1'b0;
    store_byte  = 1'b0;
    drop_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (byte_fire) begin
          // A reserved-bit header with no payload has nothing left to skip: it is dropped as it arrives.
          if (hdr_len == '0) begin
            drop_done = hdr_rsvd;
          end else if (hdr_rsvd || (hdr_len > MAX_LEN)) begin
            start_drop = 1'b1;
            state_d    = DROP;
          end else begin
            start_pkt = 1'b1;
            state_d   = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_fire) begin
          store_byte = 1'b1;
          if (idx_q == len_q - 5'd1) state_d = OUT;
        end
      end
      OUT: begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      DROP: begin
        if (byte_fire && (remain_q == 5'd1)) begin
          drop_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      payload_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      remain_q  <= '0;
      flow_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      err_q <= drop_done;
      if (drop_done && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      if (start_pkt) begin
        payload_q <= '0;
        len_q     <= hdr_len;
        flow_q    <= hdr_flow;
        idx_q     <= '0;
      end
      if (store_byte) begin
        payload_q[{idx_q, 3'b000} +: 8] <= in_data_i;
        idx_q <= idx_q + 5'd1;
      end
      if (start_drop) remain_q <= hdr_len;
      else if (state_q == DROP && byte_fire) remain_q <= remain_q - 5'd1;
    end
  end

  assign out_format_o            = trdb_format_e'(payload_q[FORMAT_LSB +: 2]);
  assign out_sync_subformat_o    = trdb_f_sync_subformat_e'(payload_q[SUBFORMAT_LSB +: 2]);
  assign out_opt_ext_subformat_o = trdb_f_opt_ext_subformat_e'(payload_q[SUBFORMAT_LSB]);
  assign out_flow_o              = flow_q;
  assign out_len_o               = len_q;
  assign out_payload_o           = payload_q;
  assign err_o                   = err_q;
  assign dropped_cnt_o           = cnt_q;

endmodule
